// File: rtl/cic_comb_chain.sv
// CIC decimator comb section: StageNum cascaded differentiators (delay DiffDelay) plus a shift-scaled output stage.
// Define CIC_COMB_ROUND_EN to round half up and saturate in the output stage instead of truncating and wrapping.
module cic_comb_chain #(
  parameter int unsigned DataWidth  = 18,
  parameter int unsigned OutWidth   = 16,
  parameter int unsigned StageNum   = 3,
  parameter int unsigned DiffDelay  = 1,
  parameter int unsigned ShiftWidth = 5
) (
  input  logic                         Clk_i,
  input  logic                         Rst_i,
  input  logic signed [DataWidth-1:0]  Data_i,
  input  logic                         DataVal_i,
  input  logic        [ShiftWidth-1:0] Shift_i,
  output logic signed [OutWidth-1:0]   Data_o,
  output logic                         DataVal_o
);

  localparam int unsigned MaxShift = DataWidth - OutWidth;

  // r_val[k] marks stage k+1 holding a fresh result; r_val[StageNum] is the output strobe.
  logic [StageNum:0]           r_val;
  logic signed [DataWidth-1:0] w_last;
  logic signed [OutWidth-1:0]  w_out;
  logic signed [OutWidth-1:0]  r_data;
  int unsigned                 w_shift;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_val <= '0;
    end else begin
      r_val <= {r_val[StageNum-1:0], DataVal_i};
    end
  end

  genvar k;
  generate
    for (k = 0; k < StageNum; k++) begin : g_stage
      logic signed [DataWidth-1:0] r_y;
      logic signed [DataWidth-1:0] r_d [DiffDelay];
      logic signed [DataWidth-1:0] w_x;
      logic                        w_v;

      if (k == 0) begin : g_first
        assign w_x = Data_i;
        assign w_v = DataVal_i;
      end else begin : g_next
        assign w_x = g_stage[k-1].r_y;
        assign w_v = r_val[k-1];
      end

      // State only moves on this stage's own valid, so input gaps leave the filter untouched.
      always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
          r_y <= '0;
          for (int unsigned j = 0; j < DiffDelay; j++) begin
            r_d[j] <= '0;
          end
        end else if (w_v) begin
          r_y    <= w_x - r_d[DiffDelay-1];
          r_d[0] <= w_x;
          for (int unsigned j = 1; j < DiffDelay; j++) begin
            r_d[j] <= r_d[j-1];
          end
        end
      end
    end
  endgenerate

  assign w_last = g_stage[StageNum-1].r_y;

  always_comb begin
    w_shift = 32'(Shift_i);
    if (w_shift > MaxShift) begin
      w_shift = MaxShift;
    end
  end

`ifdef CIC_COMB_ROUND_EN
  localparam logic signed [DataWidth:0] SatMax = (DataWidth+1)'((1 << (OutWidth-1)) - 1);
  localparam logic signed [DataWidth:0] SatMin = -SatMax - 1;

  logic signed [DataWidth:0] w_ext;
  logic signed [DataWidth:0] w_bias;
  logic signed [DataWidth:0] w_rnd;

  always_comb begin
    w_ext  = {w_last[DataWidth-1], w_last};
    w_bias = '0;
    if (w_shift != 0) begin
      w_bias = (DataWidth+1)'(1) << (w_shift - 1);
    end
    w_rnd = (w_ext + w_bias) >>> w_shift;
    if (w_rnd > SatMax) begin
      w_out = OutWidth'(SatMax);
    end else if (w_rnd < SatMin) begin
      w_out = OutWidth'(SatMin);
    end else begin
      w_out = OutWidth'(w_rnd);
    end
  end
`else
  always_comb begin
    w_out = OutWidth'(w_last >>> w_shift);
  end
`endif

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_data <= '0;
    end else if (r_val[StageNum-1]) begin
      r_data <= w_out;
    end
  end

  assign Data_o    = r_data;
  assign DataVal_o = r_val[StageNum];

endmodule

// File: tb/tb_cic_comb_chain.sv
// Scoreboard bench for cic_comb_chain: three configurations (N3/M1, N1/M2, N1/M1) with directed vectors.
module tb_cic_comb_chain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [17:0] a_d, b_d, c_d;
  logic               a_v, b_v, c_v;
  logic [4:0]         a_s, b_s, c_s;
  logic [15:0]        a_o, b_o, c_o;
  logic               a_ov, b_ov, c_ov;

  cic_comb_chain #(.DataWidth(18), .OutWidth(16), .StageNum(3), .DiffDelay(1), .ShiftWidth(5)) u_a (
    .Clk_i(clk), .Rst_i(rst), .Data_i(a_d), .DataVal_i(a_v), .Shift_i(a_s), .Data_o(a_o), .DataVal_o(a_ov));
  cic_comb_chain #(.DataWidth(18), .OutWidth(16), .StageNum(1), .DiffDelay(2), .ShiftWidth(5)) u_b (
    .Clk_i(clk), .Rst_i(rst), .Data_i(b_d), .DataVal_i(b_v), .Shift_i(b_s), .Data_o(b_o), .DataVal_o(b_ov));
  cic_comb_chain #(.DataWidth(18), .OutWidth(16), .StageNum(1), .DiffDelay(1), .ShiftWidth(5)) u_c (
    .Clk_i(clk), .Rst_i(rst), .Data_i(c_d), .DataVal_i(c_v), .Shift_i(c_s), .Data_o(c_o), .DataVal_o(c_ov));

  typedef struct {
    logic [15:0] v;
    int          due;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected output strobe, expected none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (a_ov) begin
      if (qa.size() == 0) unexpected("A strobe");
      else begin
        e = qa.pop_front();
        check16("A data", a_o, e.v);
        checki("A latency", cyc, e.due);
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) unexpected("B strobe");
      else begin
        e = qb.pop_front();
        check16("B data", b_o, e.v);
        checki("B latency", cyc, e.due);
      end
    end
    if (c_ov) begin
      if (qc.size() == 0) unexpected("C strobe");
      else begin
        e = qc.pop_front();
        check16("C data", c_o, e.v);
        checki("C latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          imp_x [6] = '{1, 0, 0, 0, 0, 0};
  logic [15:0] imp_e [6] = '{16'h0001, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0000, 16'h0000};
  logic [15:0] con_e [4] = '{16'd5, 16'd5, 16'd0, 16'd0};

  // Inputs chosen so the N=1/M=1 differences are 6,-18,6,-18,24,131071,-131071,131070,-131070.
  int          c_x  [9] = '{6, -12, -6, -24, 0, 131071, 0, 131070, 0};
  int          c_sh [9] = '{2, 2, 9, 9, 0, 2, 0, 1, 3};
`ifdef CIC_COMB_ROUND_EN
  logic [15:0] c_e  [9] = '{16'd2, 16'hFFFC, 16'd2, 16'hFFFC, 16'd24, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8001};
`else
  logic [15:0] c_e  [9] = '{16'd1, 16'hFFFB, 16'd1, 16'hFFFB, 16'd24, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000};
`endif

  initial begin
    rst = 1'b1;
    a_d = '0; b_d = '0; c_d = '0;
    a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
    a_s = '0; b_s = '0; c_s = '0;
    repeat (3) step();
    check16("reset A data", a_o, 16'h0000);
    checki("reset A valid", int'(a_ov), 0);
    check16("reset C data", c_o, 16'h0000);
    checki("reset C valid", int'(c_ov), 0);
    rst = 1'b0;
    step();

    // Back-to-back impulse
    for (int i = 0; i < 6; i++) begin
      a_d = 18'(imp_x[i]);
      a_v = 1'b1;
      qa.push_back('{imp_e[i], cyc + 4});
      step();
    end
    a_v = 1'b0;
    repeat (8) step();

    // Gapped impulse with junk data between strobes
    for (int i = 0; i < 6; i++) begin
      a_d = 18'(imp_x[i]);
      a_v = 1'b1;
      qa.push_back('{imp_e[i], cyc + 4});
      step();
      a_v = 1'b0;
      for (int g = 0; g < 4; g++) begin
        a_d = 18'($urandom);
        step();
      end
    end
    repeat (8) step();

    // Constant 5 into N=1, M=2
    for (int i = 0; i < 4; i++) begin
      b_d = 18'sd5;
      b_v = 1'b1;
      qb.push_back('{con_e[i], cyc + 2});
      step();
    end
    b_v = 1'b0;
    repeat (4) step();

    // Shift, clamp, rounding and saturation on N=1, M=1; shift held until the output stage samples it
    for (int i = 0; i < 9; i++) begin
      c_d = 18'(c_x[i]);
      c_s = 5'(c_sh[i]);
      c_v = 1'b1;
      qc.push_back('{c_e[i], cyc + 2});
      step();
      c_v = 1'b0;
      step();
    end
    repeat (4) step();

    // Reset two cycles after a strobe: that sample must never appear
    a_d = 18'sd7;
    a_v = 1'b1;
    step();
    a_v = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    check16("mid-reset A data", a_o, 16'h0000);
    check16("mid-reset C data", c_o, 16'h0000);
    checki("mid-reset A valid", int'(a_ov), 0);
    rst = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 6; i++) begin
      a_d = 18'(imp_x[i]);
      a_v = 1'b1;
      qa.push_back('{imp_e[i], cyc + 4});
      step();
    end
    a_v = 1'b0;
    repeat (10) step();

    checki("A outstanding", qa.size(), 0);
    checki("B outstanding", qb.size(), 0);
    checki("C outstanding", qc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
